uart_byte_tx: RTL and testbench
===============================

# uart_byte_tx

Serial transmitter behind the board's console link: accepts one byte per `tx_start` pulse from the console checker FSM and shifts it out as an 8N1-style asynchronous frame on `tx`. It is the downstream end of the `w_data`/`tx_start`/`tx_ready` byte handshake. It sits between the checker and the FPGA UART TX pin, at the 12 MHz board clock. Parity and stop-bit count are build-time options.

## Interface
- `CLK_FREQ`, 12_000_000, input clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `CLKS_PER_BIT` (localparam), `CLK_FREQ/BAUD`, integer division. Elaboration error if < 2.
- `DBIT`, 8, data bits per frame. Legal range 5..8.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame: 1 or 2.

Ports:
- `clk` input 1: the single clock. One clock; reset is synchronous and active-low.
- `reset` input 1: synchronous, active-low. Sampled on the `clk` rising edge; 0 resets the block.
- `tx_start` input 1: one-cycle request to send `w_data`. Honoured only when `tx_ready`=1.
- `w_data` input 8: byte to send. Bits [DBIT-1:0] are used, LSB first.
- `tx` output 1: serial line. Idles high.
- `tx_ready` output 1: level. 1 = idle and able to accept `tx_start` this cycle.
- `tx_done_tick` output 1: one-cycle pulse when the last stop bit has completed.

## Operation
- FSM states:
  - IDLE: `tx`=1, `tx_ready`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift_reg[0]; shift right once per bit.
  - PARITY: `tx`=parity bit. Skipped when PARITY=0.
  - STOP: `tx`=1 for STOP_BITS bit times.
- Bit timer: a down-counter of width `$clog2(CLKS_PER_BIT)` is loaded with CLKS_PER_BIT-1 on entry to each bit. Each bit lasts exactly CLKS_PER_BIT clocks.
- Bit counter: width `$clog2(DBIT)`, counts data bits 0..DBIT-1. It is reused for the stop-bit count.
- Acceptance: in IDLE with `tx_start`=1:
  - latch `w_data` into shift_reg;
  - compute parity as XOR of data bits, inverted for odd;
  - go to START; `tx_ready` falls on the same edge.
- Once accepted, later changes on `w_data` have no effect on the frame in flight.
- `tx_start` while `tx_ready`=0 is ignored and not queued. No error is flagged.
- Transitions:
  - START → DATA after 1 bit time.
  - DATA → PARITY or STOP after DBIT bit times.
  - PARITY → STOP after 1 bit time.
  - STOP → IDLE after STOP_BITS bit times.
- `tx_done_tick`=1 in exactly the cycle the FSM re-enters IDLE.
- `tx` is driven from a register, so there are no combinational glitches on the pin.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_done_tick`=0, FSM=IDLE, counters=0, shift_reg=0.
- Acceptance edge: `tx_start` sampled at edge E (with `tx_ready`=1). Then `tx` goes 0 and `tx_ready` goes 0 after edge E.
- Start bit: `tx`=0 for exactly CLKS_PER_BIT cycles.
- Frame length N = (1 + DBIT + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles, from the first low cycle of `tx` to the end of the last stop bit.
- After those N cycles, `tx_ready`=1 and `tx_done_tick`=1 together for one cycle.
- Back-to-back: `tx_start` in the same cycle `tx_ready` returns to 1 is accepted. The next start bit begins on the following edge, so the minimum high time between frames is STOP_BITS bit times + 1 clock.
- `tx_start` asserted for several cycles: only the first cycle (while ready) is accepted. The remaining cycles fall in the busy window and are ignored.
- Reset mid-frame: at the sampling edge the frame is aborted, `tx` returns to 1, and `tx_ready` returns to 1. No `tx_done_tick` is produced.
- `reset`=0 coincident with `tx_start`: reset wins and no frame starts.

## Test plan
- Basic 8N1 frame: set CLK_FREQ=16, BAUD=1 (16 clk/bit). Send `w_data`=0x53.
  - Sampling `tx` mid-bit gives 0,1,1,0,0,1,0,1,0,1 (start, LSB-first data, stop).
  - `tx_ready` is low for 160 cycles; one `tx_done_tick` pulse.
- Even parity, 2 stop bits: PARITY=2, STOP_BITS=2, `w_data`=0x0D.
  - Data bits are 1,0,1,1,0,0,0,0, then parity=1, then two high stop bits.
  - Frame length is 192 cycles.
- Odd parity: PARITY=1, `w_data`=0x53. Parity bit is 1.
- Back-to-back and ignored request:
  - Pulse `tx_start` with 0x41 mid-frame while busy: ignored, the line is unaffected.
  - Pulse `tx_start` with 0x42 in the `tx_done_tick` cycle: the next start bit begins 1 clock later and 0x42 is serialized correctly.
- Data stability: change `w_data` every cycle after acceptance of 0x55. `tx` still shows 0x55.
- Reset mid-frame: assert `reset`=0 for 1 cycle during data bit 3.
  - `tx`=1 and `tx_ready`=1 after that edge, and no `tx_done_tick`.
  - A following 0xFF request transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the console checker and the UART transmitter.
// The checker drives the request and data byte. The transmitter drives the
// serial line and its status.
interface uart_byte_tx_if;
    logic       tx_start;
    logic [7:0] w_data;
    logic       tx;
    logic       tx_ready;
    logic       tx_done_tick;

    // Checker side: issues bytes and watches the transmitter status.
    modport master (
        output tx_start,
        output w_data,
        input  tx,
        input  tx_ready,
        input  tx_done_tick
    );

    // Transmitter side: accepts bytes and drives the line.
    modport slave (
        input  tx_start,
        input  w_data,
        output tx,
        output tx_ready,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_byte_tx.sv
// Asynchronous serial transmitter.
// Each accepted byte is sent as one frame: a start bit, DBIT data bits
// (LSB first), an optional parity bit, and STOP_BITS stop bits.
// Each bit lasts CLK_FREQ/BAUD clocks. The line output is registered.
module uart_byte_tx #(
    parameter int unsigned CLK_FREQ  = 12_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DBIT      = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_byte_tx_if.slave  s_if
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned TMR_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W        = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DBIT - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic             PAR_EN    = (PARITY != 0);

    // Reject build options the datapath cannot honour.
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_byte_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (DBIT < 5 || DBIT > 8) begin : g_bad_dbit
        $error("uart_byte_tx: DBIT must be in 5..8");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_byte_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DBIT-1:0]   r_shift;
    logic              r_parity;
    logic              r_tx;
    logic              r_tx_ready;
    logic              r_tx_done_tick;

    logic [DBIT-1:0]   w_data_bits;
    logic              w_parity;
    logic              w_bit_end;

    // Data bits of the request and the parity bit the frame will carry.
    assign w_data_bits = s_if.w_data[DBIT-1:0];
    assign w_parity    = (^w_data_bits) ^ PAR_ODD;

    // The bit timer counts down, so it reaches zero on the last clock of a bit.
    assign w_bit_end   = (r_timer == '0);

    // Frame sequencer: bit timing, bit counting, shifting and the line driver.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_parity       <= 1'b0;
            r_tx           <= 1'b1;
            r_tx_ready     <= 1'b1;
            r_tx_done_tick <= 1'b0;
        end else begin
            r_tx_done_tick <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    if (s_if.tx_start) begin
                        // Capture the byte now. Later changes on w_data cannot reach the frame.
                        r_shift    <= w_data_bits;
                        r_parity   <= w_parity;
                        r_timer    <= TMR_LOAD;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_timer <= TMR_LOAD;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= TMR_LOAD;
                        if (r_bit_cnt == DATA_LAST) begin
                            // The bit counter is reused to count stop bits.
                            r_bit_cnt <= '0;
                            if (PAR_EN) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_timer <= TMR_LOAD;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            // Ready and done rise together. A start in this cycle is accepted.
                            r_timer        <= '0;
                            r_bit_cnt      <= '0;
                            r_tx           <= 1'b1;
                            r_tx_ready     <= 1'b1;
                            r_tx_done_tick <= 1'b1;
                            r_state        <= S_IDLE;
                        end else begin
                            r_timer   <= TMR_LOAD;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                end
            endcase
        end
    end

    // The outputs are driven directly from the registers.
    assign s_if.tx           = r_tx;
    assign s_if.tx_ready     = r_tx_ready;
    assign s_if.tx_done_tick = r_tx_done_tick;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomized scoreboard bench for uart_byte_tx. It instantiates three builds:
//   dut0 8N1, dut1 8E2, dut2 8O1, all at 16 clocks per bit.
module tb_uart_byte_tx;

    localparam int CPB  = 16;
    localparam int NDUT = 3;

    typedef struct {
        int          k;
        logic [15:0] bits;
        int          nbits;
        int          start_cyc;
    } frame_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rst_smp = 1'b0;
    int         cyc     = 0;
    int         checks  = 0;
    int         failures = 0;

    logic       start_r   [NDUT];
    logic [7:0] data_r    [NDUT];
    logic       tx_w      [NDUT];
    logic       ready_w   [NDUT];
    logic       done_w    [NDUT];
    bit         abort_exp [NDUT];
    int         cfg_par   [NDUT] = '{0, 2, 1};
    int         cfg_stop  [NDUT] = '{1, 2, 1};
    frame_t     exp_q[$];

    always #5 clk = ~clk;

    // Cycle stamp, and the reset level as the DUT sampled it at the last edge.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= reset;
    end

    uart_byte_tx_if if0 ();
    uart_byte_tx_if if1 ();
    uart_byte_tx_if if2 ();

    assign if0.tx_start = start_r[0];
    assign if0.w_data   = data_r[0];
    assign if1.tx_start = start_r[1];
    assign if1.w_data   = data_r[1];
    assign if2.tx_start = start_r[2];
    assign if2.w_data   = data_r[2];

    assign tx_w[0] = if0.tx;  assign ready_w[0] = if0.tx_ready;  assign done_w[0] = if0.tx_done_tick;
    assign tx_w[1] = if1.tx;  assign ready_w[1] = if1.tx_ready;  assign done_w[1] = if1.tx_done_tick;
    assign tx_w[2] = if2.tx;  assign ready_w[2] = if2.tx_ready;  assign done_w[2] = if2.tx_done_tick;

    uart_byte_tx #(.CLK_FREQ(16), .BAUD(1), .DBIT(8), .PARITY(0), .STOP_BITS(1))
        u_dut0 (.clk(clk), .reset(reset), .s_if(if0));
    uart_byte_tx #(.CLK_FREQ(16), .BAUD(1), .DBIT(8), .PARITY(2), .STOP_BITS(2))
        u_dut1 (.clk(clk), .reset(reset), .s_if(if1));
    uart_byte_tx #(.CLK_FREQ(16), .BAUD(1), .DBIT(8), .PARITY(1), .STOP_BITS(1))
        u_dut2 (.clk(clk), .reset(reset), .s_if(if2));

    task automatic chk(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, required %s", name, act, req);
        end
    endtask

    // Reference frame: the line level for each bit time, from the framing rules.
    function automatic frame_t build(input int k, input logic [7:0] d, input int sc);
        frame_t f;
        int     n;
        int     ones;
        f.k         = k;
        f.start_cyc = sc;
        f.bits      = '1;
        n           = 0;
        f.bits[n]   = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        ones = $countones(d);
        if (cfg_par[k] == 2) begin
            f.bits[n] = ((ones % 2) == 1);
            n++;
        end else if (cfg_par[k] == 1) begin
            f.bits[n] = ((ones % 2) == 0);
            n++;
        end
        for (int s = 0; s < cfg_stop[k]; s++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    // Monitor: each frame the line shows is checked against the scoreboard entry.
    task automatic monitor(input int k);
        frame_t     e;
        bit         aborted;
        bit         bit_ok;
        logic [2:0] bad;
        bit         have;
        forever begin
            @(negedge clk);
            if (rst_smp !== 1'b1) begin
                chk(tx_w[k] === 1'b1 && ready_w[k] === 1'b1 && done_w[k] === 1'b0,
                    $sformatf("dut%0d reset_outputs", k),
                    $sformatf("tx=%b ready=%b done=%b", tx_w[k], ready_w[k], done_w[k]),
                    "tx=1 ready=1 done=0");
                continue;
            end
            chk(done_w[k] === 1'b0, $sformatf("dut%0d stray_done", k),
                $sformatf("done=%b", done_w[k]), "done=0");
            if (tx_w[k] !== 1'b0) continue;

            have = (exp_q.size() != 0) && (exp_q[0].k == k);
            chk(have, $sformatf("dut%0d frame_expected", k), "unexpected start bit", "no frame");
            if (!have) begin
                for (int t = 0; t < 1000 && ready_w[k] !== 1'b1; t++) @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            chk(cyc == e.start_cyc, $sformatf("dut%0d start_latency", k),
                $sformatf("cycle %0d", cyc), $sformatf("cycle %0d", e.start_cyc));

            aborted = 1'b0;
            for (int b = 0; b < e.nbits && !aborted; b++) begin
                bit_ok = 1'b1;
                bad    = 3'b000;
                for (int c = 0; c < CPB; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst_smp !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (bit_ok && (tx_w[k] !== e.bits[b] || ready_w[k] !== 1'b0 || done_w[k] !== 1'b0)) begin
                        bit_ok = 1'b0;
                        bad    = {tx_w[k], ready_w[k], done_w[k]};
                    end
                end
                if (!aborted) begin
                    chk(bit_ok, $sformatf("dut%0d frame_bit%0d", k, b),
                        $sformatf("tx/ready/done=%b", bad),
                        $sformatf("tx=%b ready=0 done=0 for %0d clocks", e.bits[b], CPB));
                end
            end

            if (aborted) begin
                chk(abort_exp[k] && tx_w[k] === 1'b1 && ready_w[k] === 1'b1 && done_w[k] === 1'b0,
                    $sformatf("dut%0d abort", k),
                    $sformatf("exp=%0d tx=%b ready=%b done=%b", abort_exp[k], tx_w[k], ready_w[k], done_w[k]),
                    "exp=1 tx=1 ready=1 done=0");
                abort_exp[k] = 1'b0;
            end else begin
                @(negedge clk);
                chk(ready_w[k] === 1'b1 && done_w[k] === 1'b1 && tx_w[k] === 1'b1,
                    $sformatf("dut%0d frame_end", k),
                    $sformatf("ready=%b done=%b tx=%b", ready_w[k], done_w[k], tx_w[k]),
                    "ready=1 done=1 tx=1");
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_noise(input int k, input int n);
        repeat (n) begin
            data_r[k] = 8'($urandom);
            tick();
        end
    endtask

    // Request one byte. The data is scrambled while waiting and after acceptance.
    task automatic send(input int k, input logic [7:0] d, input int hold);
        int budget;
        budget = 0;
        tick();
        while (ready_w[k] !== 1'b1 && budget < 1000) begin
            data_r[k] = 8'($urandom);
            tick();
            budget++;
        end
        chk(ready_w[k] === 1'b1, $sformatf("dut%0d ready_timeout", k),
            $sformatf("ready=%b", ready_w[k]), "ready=1 within 1000 clocks");
        if (ready_w[k] !== 1'b1) return;
        data_r[k]  = d;
        start_r[k] = 1'b1;
        exp_q.push_back(build(k, d, cyc + 1));
        repeat (hold) tick();
        start_r[k] = 1'b0;
        data_r[k]  = 8'($urandom);
    endtask

    // One-cycle request while busy. It must be dropped.
    task automatic pulse_ignored(input int k, input logic [7:0] d);
        tick();
        chk(ready_w[k] === 1'b0, $sformatf("dut%0d busy_at_pulse", k),
            $sformatf("ready=%b", ready_w[k]), "ready=0");
        data_r[k]  = d;
        start_r[k] = 1'b1;
        tick();
        start_r[k] = 1'b0;
        data_r[k]  = 8'($urandom);
    endtask

    task automatic wait_idle(input int k);
        int budget;
        budget = 0;
        while (ready_w[k] !== 1'b1 && budget < 1000) begin
            data_r[k] = 8'($urandom);
            tick();
            budget++;
        end
        chk(ready_w[k] === 1'b1, $sformatf("dut%0d idle_timeout", k),
            $sformatf("ready=%b", ready_w[k]), "ready=1 within 1000 clocks");
        wait_noise(k, 4);
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            start_r[k]   = 1'b0;
            data_r[k]    = 8'h00;
            abort_exp[k] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            chk(tx_w[k] === 1'b1 && ready_w[k] === 1'b1 && done_w[k] === 1'b0,
                $sformatf("dut%0d reset_state", k),
                $sformatf("tx=%b ready=%b done=%b", tx_w[k], ready_w[k], done_w[k]),
                "tx=1 ready=1 done=0");
        end
        reset = 1'b1;
        repeat (2) tick();

        // 8N1: the 0x53 frame, an ignored request mid-frame, then back-to-back 0x42.
        send(0, 8'h53, 1);
        repeat (50) tick();
        pulse_ignored(0, 8'h41);
        send(0, 8'h42, 1);
        // A held request is accepted once. The data is scrambled for the whole frame.
        send(0, 8'h55, 3);
        wait_noise(0, 200);
        for (int i = 0; i < 20; i++) begin
            send(0, 8'($urandom), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) wait_noise(0, int'($urandom_range(0, 200)));
        end
        wait_idle(0);

        // Reset during data bit 3 aborts the frame without a done tick.
        send(0, 8'hA7, 1);
        repeat (70) tick();
        abort_exp[0] = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk(abort_exp[0] == 1'b0, "dut0 abort_observed",
            $sformatf("pending=%0d", abort_exp[0]), "pending=0");
        chk(tx_w[0] === 1'b1 && ready_w[0] === 1'b1, "dut0 after_abort",
            $sformatf("tx=%b ready=%b", tx_w[0], ready_w[0]), "tx=1 ready=1");

        // Reset takes priority over a start request in the same cycle.
        reset      = 1'b0;
        start_r[0] = 1'b1;
        data_r[0]  = 8'hFF;
        tick();
        reset      = 1'b1;
        start_r[0] = 1'b0;
        repeat (3) tick();
        chk(ready_w[0] === 1'b1 && tx_w[0] === 1'b1, "dut0 reset_beats_start",
            $sformatf("tx=%b ready=%b", tx_w[0], ready_w[0]), "tx=1 ready=1");
        send(0, 8'hFF, 1);
        wait_idle(0);

        // 8E2: 0x0D, then random bytes.
        send(1, 8'h0D, 1);
        for (int i = 0; i < 10; i++) begin
            send(1, 8'($urandom), 1);
            if ($urandom_range(0, 1) == 1) wait_noise(1, int'($urandom_range(0, 250)));
        end
        wait_idle(1);

        // 8O1: 0x53, then random bytes.
        send(2, 8'h53, 1);
        for (int i = 0; i < 10; i++) begin
            send(2, 8'($urandom), int'($urandom_range(1, 2)));
            if ($urandom_range(0, 1) == 1) wait_noise(2, int'($urandom_range(0, 250)));
        end
        wait_idle(2);

        chk(exp_q.size() == 0, "scoreboard_drained",
            $sformatf("%0d frames outstanding", exp_q.size()), "0 frames outstanding");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
